// File: rtl/fetch_unit.sv
// fetch_unit: RISC-V instruction fetch with PC ownership, single-outstanding imem requests and a one-entry decode slot.
// Ports: clk/rst (async active-high); PCsrc/pc_target redirect from branch unit;
// id_ready decode handshake; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata memory side;
// if_valid/if_instr/if_pc/if_pc4 decode slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCsrc,
  input  logic [31:0] pc_target,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);
  typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, if_pc_q, if_pc_d, if_pc4_q, if_pc4_d, pc_inc;
  logic        valid_q, valid_d, fire, load;
  // Requests only go out when the slot is free or draining, so a response never finds it occupied.
  assign imem_req  = !rst && state_q == REQ && (!valid_q || id_ready);
  assign fire      = imem_req && imem_gnt;
  assign load      = state_q == WAIT && imem_rvalid && !PCsrc;
  assign pc_inc    = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc4_q;
  // A redirect turns any granted-but-unreturned access into a stale one that must be drained.
  always_comb begin
    state_d = state_q;
    if (PCsrc)
      state_d = (state_q == REQ) ? (fire ? DROP : REQ) : (imem_rvalid ? REQ : DROP);
    else if (state_q == REQ)
      state_d = fire ? WAIT : REQ;
    else if (imem_rvalid)
      state_d = REQ;
  end
  always_comb begin
    pc_d     = PCsrc ? (pc_target & ~32'd3) : load ? pc_inc : pc_q;
    valid_d  = !PCsrc && (load || (valid_q && !id_ready));
    instr_d  = load ? imem_rdata : instr_q;
    if_pc_d  = load ? pc_q : if_pc_q;
    if_pc4_d = load ? pc_inc : if_pc4_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      if_pc_q  <= RESET_PC;
      if_pc4_q <= RESET_PC + 32'd4;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      if_pc_q  <= if_pc_d;
      if_pc4_q <= if_pc4_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;
  logic        clk = 0, rst = 1, PCsrc = 0, id_ready = 1, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] pc_target = 0, imem_rdata = 0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc4;
  int          checks = 0, fails = 0, cyc = 0, lat = 1, out_cnt = 0, fire_cyc = 0;
  logic        out_v = 0, out_kill = 0, fired = 0, gnt_en = 1;
  logic [31:0] out_addr = 0, fire_addr = 0, exp_pc = 0;
  logic [31:0] sbq[$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .pc_target(pc_target), .id_ready(id_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hDEAD_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive memory response, compare consumed slot against scoreboard, note any grant.
  task automatic half_a();
    logic [31:0] e;
    @(negedge clk);
    imem_gnt    = gnt_en;
    imem_rvalid = out_v && out_cnt == 0;
    imem_rdata  = imem_rvalid ? mem(out_addr) : 32'h0;
    #1;
    if (if_valid && id_ready) begin
      if (sbq.size() == 0) check("sb_extra_valid", {31'b0, if_valid}, 32'd0);
      else begin
        e = sbq.pop_front();
        check("if_pc", if_pc, e);
        check("if_instr", if_instr, mem(e));
        check("if_pc4", if_pc4, e + 32'd4);
      end
    end
    fired     = imem_req && imem_gnt;
    fire_addr = imem_addr;
    if (fired) fire_cyc = cyc;
  endtask

  // Advance memory model on the edge; surviving responses become expected slot contents.
  task automatic half_b();
    @(posedge clk);
    if (imem_rvalid) begin
      if (!out_kill && !PCsrc) sbq.push_back(out_addr);
      out_v = 0;
    end else if (out_v) begin
      out_cnt--;
      if (PCsrc) out_kill = 1;
    end
    if (fired) begin
      out_v    = 1;
      out_addr = fire_addr;
      out_cnt  = lat - 1;
      out_kill = PCsrc;
    end
    cyc++;
    #1;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  // Returns inside the granting cycle with half_b still to run.
  task automatic wait_fire(input string tag);
    for (int i = 0; i < 20; i++) begin
      half_a();
      if (fired) return;
      half_b();
    end
    check({tag, "_timeout"}, {31'b0, fired}, 32'd1);
    half_a();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    #1;
    PCsrc = 1;
    pc_target = 32'h500;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0000_0013);
    check("rst_pc", if_pc, 32'h0);
    check("rst_pc4", if_pc4, 32'h4);
    check("rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    PCsrc = 0;
    rst = 0;
    cyc = 1;
    for (int c = 1; c <= 7; c++) begin
      half_a();
      check("s1_fire", {31'b0, fired}, {31'b0, c % 2 == 1});
      if (fired) check("s1_addr", imem_addr, 32'((c - 1) * 2));
      check("s1_valid", {31'b0, if_valid}, {31'b0, c >= 3 && c % 2 == 1});
      half_b();
    end
    id_ready = 0;
    for (int i = 0; i < 10; i++) begin
      half_a();
      if (if_valid) break;
      half_b();
    end
    check("stall_seen", {31'b0, if_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) half_a();
      exp_pc = sbq.size() > 0 ? sbq[0] : 32'hFFFF_FFFF;
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_valid", {31'b0, if_valid}, 32'd1);
      check("stall_pc", if_pc, exp_pc);
      check("stall_instr", if_instr, mem(exp_pc));
      check("stall_pc4", if_pc4, exp_pc + 32'd4);
      half_b();
    end
    id_ready = 1;
    half_a();
    check("resume_req", {31'b0, imem_req}, 32'd1);
    check("resume_addr", imem_addr, exp_pc + 32'd4);
    half_b();
    lat = 2;
    wait_fire("s3a");
    half_b();
    PCsrc = 1;
    pc_target = 32'h100;
    tick();
    PCsrc = 0;
    half_a();
    check("s3a_flush_valid", {31'b0, if_valid}, 32'd0);
    check("s3a_drop_req", {31'b0, imem_req}, 32'd0);
    half_b();
    wait_fire("s3a_tgt");
    check("s3a_addr", fire_addr, 32'h100);
    half_b();
    lat = 1;
    wait_fire("s3b");
    half_b();
    PCsrc = 1;
    pc_target = 32'h180;
    tick();
    PCsrc = 0;
    half_a();
    check("s3b_flush_valid", {31'b0, if_valid}, 32'd0);
    check("s3b_req", {31'b0, imem_req}, 32'd1);
    check("s3b_addr", imem_addr, 32'h180);
    half_b();
    gnt_en = 0;
    repeat (3) tick();
    PCsrc = 1;
    pc_target = 32'h103;
    tick();
    PCsrc = 0;
    half_a();
    check("align_req", {31'b0, imem_req}, 32'd1);
    check("align_addr", imem_addr, 32'h100);
    half_b();
    gnt_en = 1;
    PCsrc = 1;
    pc_target = 32'h200;
    half_a();
    check("s4_fire", {31'b0, fired}, 32'd1);
    half_b();
    PCsrc = 0;
    half_a();
    check("s4_drop_req", {31'b0, imem_req}, 32'd0);
    check("s4_valid", {31'b0, if_valid}, 32'd0);
    half_b();
    wait_fire("s4_tgt");
    check("s4_addr", fire_addr, 32'h200);
    half_b();
    PCsrc = 1;
    pc_target = 32'hFFFF_FFFC;
    tick();
    PCsrc = 0;
    wait_fire("wrap_a");
    check("wrap_addr", fire_addr, 32'hFFFF_FFFC);
    half_b();
    wait_fire("wrap_b");
    check("wrap_next_addr", fire_addr, 32'h0);
    check("wrap_pc4", if_pc4, 32'h0);
    half_b();
    lat = 3;
    wait_fire("r_a");
    half_b();
    wait_fire("r_b");
    half_b();
    half_a();
    rst = 1;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_valid", {31'b0, if_valid}, 32'd0);
    check("arst_instr", if_instr, 32'h0000_0013);
    check("arst_pc", if_pc, 32'h0);
    check("arst_pc4", if_pc4, 32'h4);
    check("arst_addr", imem_addr, 32'h0);
    out_v = 0;
    fired = 0;
    imem_rvalid = 0;
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 0;
    cyc = 1;
    lat = 1;
    wait_fire("post_rst");
    check("post_rst_addr", fire_addr, 32'h0);
    check("post_rst_cyc", fire_cyc, 32'd1);
    half_b();
    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
